floor_scroll_ctrl: RTL and testbench



---
 rtl/floor_scroll_ctrl_pkg.sv | 22 ++
 rtl/floor_speed_ramp.sv | 44 ++++
 rtl/floor_scroll_ctrl.sv | 109 ++++++++++
 tb/tb_floor_scroll_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/floor_scroll_ctrl_pkg.sv
// Shared game constants for the runner: screen geometry, ground band rows,
// and the ground-scroll state encoding.
package floor_scroll_ctrl_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int GRASS_Y0 = 375;
  localparam int GRASS_Y1 = 390;
  localparam int FLOOR_Y0 = 391;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } scroll_state_t;

  // True for rows that belong to the floor band (below the grass, on screen).
  function automatic logic in_floor_band(input logic [9:0] row);
    return (row >= 10'(FLOOR_Y0)) && (row <= 10'(SCREEN_H - 1));
  endfunction

endpackage

// File: rtl/floor_speed_ramp.sv
// Ramp counter plus saturating speed register for the ground scroll.
// Counts advancing frames and bumps speed every RAMP_FRAMES of them.
module floor_speed_ramp #(
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 8,
  parameter int RAMP_FRAMES = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  output logic [3:0] speed
);

  localparam int CNT_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam int SPEED_START = (SPEED_INIT > SPEED_MAX) ? SPEED_MAX : SPEED_INIT;

  logic [CNT_W-1:0] ramp_cnt;
  logic             ramp_last;

  assign ramp_last = (ramp_cnt == CNT_W'(RAMP_FRAMES - 1));

  // The new speed only affects the frame after the one that triggered it,
  // because the offset adder samples the register value before the update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp_cnt <= '0;
      speed    <= 4'(SPEED_START);
    end else if (clear) begin
      ramp_cnt <= '0;
      speed    <= 4'(SPEED_START);
    end else if (advance) begin
      if (ramp_last) begin
        ramp_cnt <= '0;
        if (speed < 4'(SPEED_MAX)) begin
          speed <= speed + 4'd1;
        end
      end else begin
        ramp_cnt <= ramp_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/floor_scroll_ctrl.sv
// Ground scroll sequencer: advances the floor offset once per frame, freezes on
// a hit, restarts on start, and marks tile seams in the floor band.
// Optional speed ramp enabled by defining FLOOR_SPEED_RAMP_EN.
module floor_scroll_ctrl
  import floor_scroll_ctrl_pkg::*;
#(
  parameter int TILE_W      = 128,
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 8,
  parameter int RAMP_FRAMES = 600,
  localparam int OFF_W      = $clog2(TILE_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             start,
  input  logic             check_hit,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  output logic [OFF_W-1:0] offset,
  output logic [3:0]       speed,
  output logic             running,
  output logic             frozen,
  output logic             tile_wrap,
  output logic [15:0]      tiles_passed,
  output logic             floor_seam
);

  scroll_state_t    state;
  logic             advance;
  logic             restart;
  logic [OFF_W:0]   sum;
  logic [OFF_W-1:0] seam_col;

  // check_hit outranks frame_tick, so a hit frame never moves the ground.
  assign advance = (state == ST_RUN) && frame_tick && !check_hit;
  assign restart = (state == ST_HIT) && start;
  assign sum     = {1'b0, offset} + (OFF_W + 1)'(speed);

`ifdef FLOOR_SPEED_RAMP_EN
  floor_speed_ramp #(
    .SPEED_INIT  (SPEED_INIT),
    .SPEED_MAX   (SPEED_MAX),
    .RAMP_FRAMES (RAMP_FRAMES)
  ) u_speed_ramp (
    .clk     (clk),
    .reset   (reset),
    .clear   (restart),
    .advance (advance),
    .speed   (speed)
  );
`else
  localparam int SPEED_START = (SPEED_INIT > SPEED_MAX) ? SPEED_MAX : SPEED_INIT;
  assign speed = 4'(SPEED_START);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      offset       <= '0;
      running      <= 1'b0;
      frozen       <= 1'b0;
      tile_wrap    <= 1'b0;
      tiles_passed <= '0;
    end else begin
      tile_wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (check_hit) begin
            state   <= ST_HIT;
            running <= 1'b0;
            frozen  <= 1'b1;
          end else if (frame_tick) begin
            offset    <= sum[OFF_W-1:0];
            tile_wrap <= sum[OFF_W];
            if (sum[OFF_W] && (tiles_passed != 16'hFFFF)) begin
              tiles_passed <= tiles_passed + 16'd1;
            end
          end
        end
        ST_HIT: begin
          if (start) begin
            state        <= ST_RUN;
            offset       <= '0;
            tiles_passed <= '0;
            running      <= 1'b1;
            frozen       <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          frozen  <= 1'b0;
        end
      endcase
    end
  end

  // Tile width is a power of two, so the modulo is just the low OFF_W bits.
  assign seam_col   = OFF_W'(x) + offset;
  assign floor_seam = in_floor_band(y) && (seam_col == '0);

endmodule

// File: tb/tb_floor_scroll_ctrl.sv
// Self-checking bench for floor_scroll_ctrl: reference model feeding an
// expected queue, plus directed checks on wrap, hit, seam and async reset.
module tb_floor_scroll_ctrl;

  localparam int TILE_W      = 128;
  localparam int OFF_W       = 7;
  localparam int SPEED_INIT  = 1;
  localparam int SPEED_MAX   = 3;
  localparam int RAMP_FRAMES = 4;
`ifdef FLOOR_SPEED_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  typedef struct packed {
    logic [OFF_W-1:0] off;
    logic [3:0]       spd;
    logic             run;
    logic             frz;
    logic             wrap;
    logic [15:0]      tiles;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  logic             clk = 1'b0;
  logic             reset;
  logic             frame_tick;
  logic             start;
  logic             check_hit;
  logic [9:0]       x;
  logic [9:0]       y;
  logic [OFF_W-1:0] offset;
  logic [3:0]       speed;
  logic             running;
  logic             frozen;
  logic             tile_wrap;
  logic [15:0]      tiles_passed;
  logic             floor_seam;

  int n_cmp = 0;
  int n_bad = 0;
  int wraps_seen = 0;
  logic [OBS_W-1:0] exp_q[$];

  // reference model state (0 idle, 1 run, 2 hit)
  int m_state, m_off, m_spd, m_cnt, m_tiles;
  bit m_wrap;

  floor_scroll_ctrl #(
    .TILE_W      (TILE_W),
    .SPEED_INIT  (SPEED_INIT),
    .SPEED_MAX   (SPEED_MAX),
    .RAMP_FRAMES (RAMP_FRAMES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .check_hit    (check_hit),
    .x            (x),
    .y            (y),
    .offset       (offset),
    .speed        (speed),
    .running      (running),
    .frozen       (frozen),
    .tile_wrap    (tile_wrap),
    .tiles_passed (tiles_passed),
    .floor_seam   (floor_seam)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_state = 0; m_off = 0; m_spd = SPEED_INIT; m_cnt = 0; m_tiles = 0; m_wrap = 1'b0;
  endtask

  task automatic model_step(input bit ft, input bit st, input bit hit);
    int s;
    m_wrap = 1'b0;
    case (m_state)
      0: if (st) m_state = 1;
      1: begin
        if (hit) m_state = 2;
        else if (ft) begin
          s = m_off + m_spd;
          m_wrap = (s >= TILE_W);
          m_off = s % TILE_W;
          if (m_wrap && m_tiles < 65535) m_tiles++;
          if (RAMP_ON) begin
            if (m_cnt == RAMP_FRAMES - 1) begin
              m_cnt = 0;
              if (m_spd < SPEED_MAX) m_spd++;
            end else m_cnt++;
          end
        end
      end
      default: if (st) begin
        m_state = 1; m_off = 0; m_spd = SPEED_INIT; m_cnt = 0; m_tiles = 0;
      end
    endcase
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.off   = OFF_W'(m_off);
    o.spd   = 4'(m_spd);
    o.run   = (m_state == 1);
    o.frz   = (m_state == 2);
    o.wrap  = m_wrap;
    o.tiles = 16'(m_tiles);
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input bit ft, input bit st, input bit hit);
    obs_t e;
    @(negedge clk);
    frame_tick = ft; start = st; check_hit = hit;
    model_step(ft, st, hit);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    if (tile_wrap === 1'b1) wraps_seen++;
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'd1, 32'd0);
    end else begin
      e = obs_t'(exp_q.pop_front());
      check("offset", offset, e.off);
      check("speed", speed, e.spd);
      check("running", running, e.run);
      check("frozen", frozen, e.frz);
      check("tile_wrap", tile_wrap, e.wrap);
      check("tiles_passed", tiles_passed, e.tiles);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_offset"}, offset, 0);
    check({tag, "_speed"}, speed, SPEED_INIT);
    check({tag, "_running"}, running, 0);
    check({tag, "_frozen"}, frozen, 0);
    check({tag, "_wrap"}, tile_wrap, 0);
    check({tag, "_tiles"}, tiles_passed, 0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct { int sx; int sy; bit exp; } seam_t;
  seam_t seam_tab[8];
  bit done;

  initial begin
    seam_tab[0] = '{118, 400, 1'b1};
    seam_tab[1] = '{118, 380, 1'b0};
    seam_tab[2] = '{119, 400, 1'b0};
    seam_tab[3] = '{118, 391, 1'b1};
    seam_tab[4] = '{118, 390, 1'b0};
    seam_tab[5] = '{246, 479, 1'b1};
    seam_tab[6] = '{118, 480, 1'b0};
    seam_tab[7] = '{0,   400, 1'b0};

    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; check_hit = 1'b0;
    x = '0; y = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    // hit ignored in IDLE, then start and three frames at speed 1
    cycle(1, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    wraps_seen = 0;
    repeat (3) cycle(1, 0, 0);
    check("t1_offset", offset, 3);
    check("t1_running", running, 1);
    check("t1_no_wrap", wraps_seen, 0);

    // ramp: frames 4..12
    for (int i = 4; i <= 12; i++) begin
      cycle(1, 0, 0);
      if (i == 4)  check("ramp_speed_f4", speed, RAMP_ON ? 2 : 1);
      if (i == 8)  check("ramp_speed_f8", speed, RAMP_ON ? 3 : 1);
      if (i == 12) check("ramp_speed_f12", speed, RAMP_ON ? 3 : 1);
    end
    check("ramp_offset_f12", offset, RAMP_ON ? 24 : 12);
    cycle(1, 1, 0);  // start during RUN only advances

    // hit with simultaneous frame_tick freezes the current offset
    begin
      int held;
      held = m_off;
      cycle(1, 0, 1);
      check("hit_offset", offset, held);
      check("hit_frozen", frozen, 1);
      repeat (3) cycle(1, 0, 0);
      check("hit_hold", offset, held);
      cycle(1, 1, 0);
      check("restart_offset", offset, 0);
      check("restart_running", running, 1);
      check("restart_tiles", tiles_passed, 0);
    end

    // run to the first wrap
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      cycle(1, 0, 0);
      if (tile_wrap === 1'b1) done = 1'b1;
    end
    check("wrap_within_budget", done, 1);
    check("wrap_offset", offset, RAMP_ON ? 1 : 0);
    check("wrap_tiles", tiles_passed, 1);
    cycle(0, 0, 0);
    check("wrap_one_cycle", tile_wrap, 0);

    // seam marker at offset 10
    cycle(0, 0, 1);
    cycle(0, 1, 0);
    for (int k = 0; k < 200 && m_off != 10; k++) cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("seam_offset", offset, 10);
    foreach (seam_tab[i]) begin
      x = 10'(seam_tab[i].sx);
      y = 10'(seam_tab[i].sy);
      #1;
      check($sformatf("seam_x%0d_y%0d", seam_tab[i].sx, seam_tab[i].sy), floor_seam, seam_tab[i].exp);
    end

    // asynchronous reset mid-run at offset 77
    for (int k = 0; k < 300 && m_off != 77; k++) cycle(1, 0, 0);
    check("pre_reset_offset", offset, 77);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    model_reset();
    check("queue_after_reset", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b0;

    // random traffic against the model
    cycle(0, 1, 0);
    for (int k = 0; k < 200; k++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
